ins_cyc_ctrl: RTL



---
 rtl/ins_cyc_ctrl_pkg.sv | 50 +++++
 rtl/ins_cyc_ctrl_instr_counter.sv | 23 ++
 rtl/ins_cyc_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ins_cyc_ctrl_pkg.sv
// Shared types and constants for the instruction-cycle control unit.
// The PAUSE state exists only when INS_CYC_SINGLE_STEP_EN is defined.
package ins_cyc_pkg;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_SUB,
    S_INPUT,
    S_INPUT_REL,
    S_JZ,
    S_JPOS,
    S_HALT
`ifdef INS_CYC_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  typedef struct packed {
    logic       irload;
    logic       jmpmux;
    logic       pcload;
    logic       meminst;
    logic       memwr;
    logic [1:0] asel;
    logic       aload;
    logic       sub;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/ins_cyc_ctrl_instr_counter.sv
// Retired-instruction counter: increments once per enabled cycle and wraps.
module instr_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ins_cyc_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit instruction-cycle datapath.
// Optional single-step mode (Step port, PAUSE state) with INS_CYC_SINGLE_STEP_EN.
// Handshake: Enter is a level strobe; one INPUT load per rising Enter, re-armed only after Enter returns low.
module ins_cyc_ctrl
  import ins_cyc_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int OP_WIDTH  = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [OP_WIDTH-1:0]  IR,
  input  logic                 Aeq0,
  input  logic                 Apos,
  input  logic                 Enter,
`ifdef INS_CYC_SINGLE_STEP_EN
  input  logic                 Step,
`endif
  output logic                 IRload,
  output logic                 JMPmux,
  output logic                 PCload,
  output logic                 Meminst,
  output logic                 MemWr,
  output logic [1:0]           Asel,
  output logic                 Aload,
  output logic                 Sub,
  output logic                 Halt,
  output logic [CNT_WIDTH-1:0] InstrCount,
  output state_t               dbg_state_o
);

  if (OP_WIDTH != 3) begin : g_op_width_check
    $error("ins_cyc_ctrl: OP_WIDTH must be 3");
  end

`ifdef INS_CYC_SINGLE_STEP_EN
  localparam state_t EXEC_DONE = S_PAUSE;
  logic step_q;
`else
  localparam state_t EXEC_DONE = S_FETCH;
`endif

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (IR)
          OP_LOAD:  state_d = S_LOAD;
          OP_STORE: state_d = S_STORE;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_INPUT: state_d = S_INPUT;
          OP_JZ:    state_d = S_JZ;
          OP_JPOS:  state_d = S_JPOS;
          default:  state_d = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_d = EXEC_DONE;
      S_INPUT:     if (Enter) state_d = S_INPUT_REL;
      S_INPUT_REL: if (!Enter) state_d = EXEC_DONE;
      S_HALT:      state_d = S_HALT;
`ifdef INS_CYC_SINGLE_STEP_EN
      S_PAUSE:     if (Step && !step_q) state_d = S_FETCH;
`endif
      default:     state_d = S_START;
    endcase
  end

  // Outputs are decoded from the next state so they arrive registered with the state.
  always_comb begin
    ctrl_d = CTRL_IDLE;
    case (state_d)
      S_FETCH: begin
        ctrl_d.irload = 1'b1;
        ctrl_d.pcload = 1'b1;
      end
      S_DECODE: ctrl_d.meminst = 1'b1;
      S_LOAD: begin
        ctrl_d.meminst = 1'b1;
        ctrl_d.asel    = ASEL_MEM;
        ctrl_d.aload   = 1'b1;
      end
      S_STORE: begin
        ctrl_d.meminst = 1'b1;
        ctrl_d.memwr   = 1'b1;
      end
      S_ADD: begin
        ctrl_d.meminst = 1'b1;
        ctrl_d.asel    = ASEL_ALU;
        ctrl_d.aload   = 1'b1;
      end
      S_SUB: begin
        ctrl_d.meminst = 1'b1;
        ctrl_d.asel    = ASEL_ALU;
        ctrl_d.aload   = 1'b1;
        ctrl_d.sub     = 1'b1;
      end
      S_INPUT: ctrl_d.asel = ASEL_IN;
      S_JZ: begin
        ctrl_d.jmpmux = 1'b1;
        ctrl_d.pcload = Aeq0;
      end
      S_JPOS: begin
        ctrl_d.jmpmux = 1'b1;
        ctrl_d.pcload = Apos;
      end
      S_HALT:  ctrl_d.halt = 1'b1;
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_START;
      ctrl_q  <= CTRL_IDLE;
`ifdef INS_CYC_SINGLE_STEP_EN
      step_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
`ifdef INS_CYC_SINGLE_STEP_EN
      step_q  <= Step;
`endif
    end
  end

  instr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instr_counter (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .en_i    (state_q == S_FETCH),
    .count_o (InstrCount)
  );

  assign IRload      = ctrl_q.irload;
  assign JMPmux      = ctrl_q.jmpmux;
  assign PCload      = ctrl_q.pcload;
  assign Meminst     = ctrl_q.meminst;
  assign MemWr       = ctrl_q.memwr;
  assign Asel        = ctrl_q.asel;
  // Aload in INPUT follows Enter directly so the strobe loads in the same cycle.
  assign Aload       = ctrl_q.aload | ((state_q == S_INPUT) & Enter);
  assign Sub         = ctrl_q.sub;
  assign Halt        = ctrl_q.halt;
  assign dbg_state_o = state_q;

endmodule
